// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, load-data extraction and register-file writeback
//
// Optional feature macro: MEM_WB_LWLR_EN enables LWL/LWR unaligned-load merging.
// Without it, LWL/LWR (ldtype 101/110) never write and the rt_old register is absent.
//
// Ports:
//   clk, resetn                  core clock (rising edge), asynchronous active-low reset
//   stall, flush                 hold WB contents / load a bubble (flush wins)
//   m_valid, m_pc, m_regwrite,   MEM-stage instruction fields latched into WB
//   m_wa, m_memtoreg, m_alu,
//   m_ldtype, m_addr_lo, m_rt_old
//   data_sram_rdata              SRAM read data, valid in the first WB cycle of a load
//   rf_we, rf_wa, rf_wd          register-file write port (committed on the following falling edge)
//   debug_wb_*                   writeback trace

module mem_wb_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stall,
    input  logic            flush,
    input  logic            m_valid,
    input  logic [PC_W-1:0] m_pc,
    input  logic            m_regwrite,
    input  logic [4:0]      m_wa,
    input  logic            m_memtoreg,
    input  logic [31:0]     m_alu,
    input  logic [2:0]      m_ldtype,
    input  logic [1:0]      m_addr_lo,
    input  logic [31:0]     m_rt_old,
    input  logic [31:0]     data_sram_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [31:0]     rf_wd,
    output logic [PC_W-1:0] debug_wb_pc,
    output logic [3:0]      debug_wb_rf_wen,
    output logic [4:0]      debug_wb_rf_wnum,
    output logic [31:0]     debug_wb_rf_wdata
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [2:0] LT_LWL = 3'b101;
    localparam logic [2:0] LT_LWR = 3'b110;

    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } rd_state_t;

    rd_state_t       state_q;
    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic            regwrite_q;
    logic [4:0]      wa_q;
    logic            memtoreg_q;
    logic [2:0]      ldtype_q;
    logic [1:0]      addr_lo_q;
    logic [31:0]     alu_q;
    logic [31:0]     rdata_q;

`ifdef MEM_WB_LWLR_EN
    logic [31:0]     rt_old_q;
`else
    logic            unused_rt_old;
    assign unused_rt_old = ^m_rt_old;
`endif

    // Pipeline register plus read-data hold FSM. Every register load (instruction
    // or bubble) returns to FRESH; the first stalled cycle snapshots the SRAM bus
    // because the SRAM only presents the load data in the first WB cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FRESH;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            regwrite_q <= 1'b0;
            wa_q       <= 5'd0;
            memtoreg_q <= 1'b0;
            ldtype_q   <= LT_LW;
            addr_lo_q  <= 2'd0;
            alu_q      <= 32'd0;
            rdata_q    <= 32'd0;
`ifdef MEM_WB_LWLR_EN
            rt_old_q   <= 32'd0;
`endif
        end else if (flush) begin
            valid_q <= 1'b0;
            state_q <= FRESH;
        end else if (stall) begin
            if (state_q == FRESH) begin
                rdata_q <= data_sram_rdata;
                state_q <= HELD;
            end
        end else begin
            state_q    <= FRESH;
            valid_q    <= m_valid;
            pc_q       <= m_pc;
            regwrite_q <= m_regwrite;
            wa_q       <= m_wa;
            memtoreg_q <= m_memtoreg;
            ldtype_q   <= m_ldtype;
            addr_lo_q  <= m_addr_lo;
            alu_q      <= m_alu;
`ifdef MEM_WB_LWLR_EN
            rt_old_q   <= m_rt_old;
`endif
        end
    end

    logic [31:0] rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic        lwlr_block;

    always_comb begin
        rd = (state_q == HELD) ? rdata_q : data_sram_rdata;

        case (addr_lo_q)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase

        // Halfword loads are aligned, so only the upper offset bit matters.
        half_sel = addr_lo_q[1] ? rd[31:16] : rd[15:0];

        lwlr_block = 1'b0;
        case (ldtype_q)
            LT_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ld_data = {24'd0, byte_sel};
            LT_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  ld_data = {16'd0, half_sel};
`ifdef MEM_WB_LWLR_EN
            // LWL fills the high bytes of rt with the low bytes of the word.
            LT_LWL: begin
                case (addr_lo_q)
                    2'd0:    ld_data = {rd[7:0],  rt_old_q[23:0]};
                    2'd1:    ld_data = {rd[15:0], rt_old_q[15:0]};
                    2'd2:    ld_data = {rd[23:0], rt_old_q[7:0]};
                    default: ld_data = rd;
                endcase
            end
            // LWR fills the low bytes of rt with the high bytes of the word.
            LT_LWR: begin
                case (addr_lo_q)
                    2'd0:    ld_data = rd;
                    2'd1:    ld_data = {rt_old_q[31:24], rd[31:8]};
                    2'd2:    ld_data = {rt_old_q[31:16], rd[31:16]};
                    default: ld_data = {rt_old_q[31:8],  rd[31:24]};
                endcase
            end
`else
            LT_LWL, LT_LWR: begin
                ld_data    = rd;
                lwlr_block = 1'b1;
            end
`endif
            // LW and the unused encoding 111 both pass the word through.
            default: ld_data = rd;
        endcase
    end

    // Writes are suppressed while stalled so each instruction writes exactly
    // once, on its last WB cycle.
    assign rf_we = valid_q & regwrite_q & (wa_q != 5'd0) & ~stall & ~lwlr_block;
    assign rf_wa = wa_q;
    assign rf_wd = memtoreg_q ? ld_data : alu_q;

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = wa_q;
    assign debug_wb_rf_wdata = rf_wd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic        m_regwrite = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic        m_memtoreg = 1'b0;
    logic [31:0] m_alu = 32'd0;
    logic [2:0]  m_ldtype = 3'd0;
    logic [1:0]  m_addr_lo = 2'd0;
    logic [31:0] m_rt_old = 32'd0;
    logic [31:0] data_sram_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.PC_W(32)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_regwrite(m_regwrite), .m_wa(m_wa),
        .m_memtoreg(m_memtoreg), .m_alu(m_alu), .m_ldtype(m_ldtype),
        .m_addr_lo(m_addr_lo), .m_rt_old(m_rt_old), .data_sram_rdata(data_sram_rdata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Present one MEM-stage instruction, clock it into WB, then drop m_valid.
    task automatic issue(input logic rw, input logic [4:0] wa, input logic mtr,
                         input logic [31:0] alu, input logic [2:0] lt,
                         input logic [1:0] off, input logic [31:0] rt, input logic [31:0] pc);
        m_valid = 1'b1; m_regwrite = rw; m_wa = wa; m_memtoreg = mtr; m_alu = alu;
        m_ldtype = lt; m_addr_lo = off; m_rt_old = rt; m_pc = pc;
        @(posedge clk); #1;
        m_valid = 1'b0; m_regwrite = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wd !== 32'd0 || debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b wd=%h pc=%h wen=%h, expected all 0", rf_we, rf_wd, debug_wb_pc, debug_wb_rf_wen);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        // Mid-run reset while a write is pending in WB
        issue(1'b1, 5'd3, 1'b0, 32'hCAFEF00D, 3'd0, 2'd0, 32'd0, 32'h0000_1000);
        checks++;
        if (rf_we !== 1'b1 || rf_wd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pre_reset_write: we=%b wd=%h, expected 1 cafef00d", rf_we, rf_wd);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wd !== 32'd0 || rf_wa !== 5'd0 || debug_wb_pc !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: we=%b wd=%h wa=%0d pc=%h, expected all 0", rf_we, rf_wd, rf_wa, debug_wb_pc);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        // Reset asserted mid-stall discards the held load
        issue(1'b1, 5'd4, 1'b1, 32'd0, 3'd0, 2'd0, 32'd0, 32'h0000_1004);
        data_sram_rdata = 32'h5555AAAA;
        stall = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        stall = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_stall: we=%b wd=%h, expected 0 00000000", rf_we, rf_wd);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: we=%b, expected 0", rf_we);
        end
    endtask

    task automatic test_alu_writeback();
        issue(1'b1, 5'd8, 1'b0, 32'h12345678, 3'd0, 2'd0, 32'd0, 32'hBFC0_0010);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd8 || rf_wd !== 32'h12345678) begin
            errors++;
            $display("FAIL alu_wb: we=%b wa=%0d wd=%h, expected 1 8 12345678", rf_we, rf_wa, rf_wd);
        end
        checks++;
        if (debug_wb_pc !== 32'hBFC0_0010 || debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== 5'd8 ||
            debug_wb_rf_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL alu_trace: pc=%h wen=%h wnum=%0d wdata=%h, expected bfc00010 f 8 12345678",
                     debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        issue(1'b1, 5'd0, 1'b0, 32'h12345678, 3'd0, 2'd0, 32'd0, 32'hBFC0_0014);
        checks++;
        if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'd0) begin
            errors++;
            $display("FAIL alu_wa0: we=%b wen=%h, expected 0 0", rf_we, debug_wb_rf_wen);
        end
        issue(1'b0, 5'd9, 1'b0, 32'h1, 3'd0, 2'd0, 32'd0, 32'hBFC0_0018);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_noregwrite: we=%b, expected 0", rf_we);
        end
    endtask

    task automatic test_load_extract();
        logic [2:0]  lt  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111, 3'b001, 3'b011};
        logic [1:0]  off [8] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1};
        logic [31:0] exp [8] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                 32'h80FF7F01, 32'h80FF7F01, 32'h0000007F, 32'h00007F01};
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 5'd10, 1'b1, 32'hDEAD0000, lt[i], off[i], 32'd0, 32'h100 + i);
            data_sram_rdata = 32'h80FF7F01;
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_wd !== exp[i]) begin
                errors++;
                $display("FAIL load_%0d type=%b off=%0d: we=%b wd=%h, expected 1 %h", i, lt[i], off[i], rf_we, rf_wd, exp[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        int writes = 0;
        issue(1'b1, 5'd5, 1'b1, 32'd0, 3'd0, 2'd0, 32'd0, 32'h200);
        data_sram_rdata = 32'hDEADBEEF;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_we_cycle%0d: we=%b, expected 0", c, rf_we);
            end
            @(posedge clk); #1;
            data_sram_rdata = 32'h0;
        end
        stall = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_wd !== 32'hDEADBEEF || rf_wa !== 5'd5) begin
            errors++;
            $display("FAIL stall_release: we=%b wd=%h wa=%0d, expected 1 deadbeef 5", rf_we, rf_wd, rf_wa);
        end
        for (int c = 0; c < 3; c++) begin
            if (rf_we === 1'b1) writes++;
            @(posedge clk); #1;
        end
        checks++;
        if (writes !== 1) begin
            errors++;
            $display("FAIL stall_write_count: got %0d writes, expected 1", writes);
        end
    endtask

    task automatic test_flush_priority();
        int writes = 0;
        issue(1'b1, 5'd6, 1'b1, 32'd0, 3'd0, 2'd0, 32'd0, 32'h300);
        data_sram_rdata = 32'h0BADF00D;
        stall = 1'b1;
        flush = 1'b1;
        #1;
        if (rf_we === 1'b1) writes++;
        @(posedge clk); #1;
        stall = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (rf_we === 1'b1) writes++;
            @(posedge clk); #1;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL flush_no_write: got %0d writes, expected 0", writes);
        end
        issue(1'b1, 5'd7, 1'b0, 32'hA5A5A5A5, 3'd0, 2'd0, 32'd0, 32'h304);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL flush_next: we=%b wa=%0d wd=%h, expected 1 7 a5a5a5a5", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_lwl_lwr();
        issue(1'b1, 5'd11, 1'b1, 32'd0, 3'b101, 2'd1, 32'h11223344, 32'h400);
        data_sram_rdata = 32'hAABBCCDD;
        #1;
        checks++;
`ifdef MEM_WB_LWLR_EN
        if (rf_we !== 1'b1 || rf_wd !== 32'hCCDD3344) begin
            errors++;
            $display("FAIL lwl_off1: we=%b wd=%h, expected 1 ccdd3344", rf_we, rf_wd);
        end
`else
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL lwl_disabled: we=%b, expected 0", rf_we);
        end
`endif
        issue(1'b1, 5'd12, 1'b1, 32'd0, 3'b110, 2'd1, 32'h11223344, 32'h404);
        data_sram_rdata = 32'hAABBCCDD;
        #1;
        checks++;
`ifdef MEM_WB_LWLR_EN
        if (rf_we !== 1'b1 || rf_wd !== 32'h11AABBCC) begin
            errors++;
            $display("FAIL lwr_off1: we=%b wd=%h, expected 1 11aabbcc", rf_we, rf_wd);
        end
`else
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL lwr_disabled: we=%b, expected 0", rf_we);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_load_extract();
        test_stall_hold();
        test_flush_priority();
        test_lwl_lwr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

- Pipeline register and writeback datapath between the MEM stage and the register file.
- Latches MEM-stage results on the rising edge and extracts, sign- or zero-extends and aligns load data from the data SRAM read port.
- Drives the register-file write port (write enable, write address, write data), which the register file commits on the following falling edge.
- Holds SRAM read data across stalls and emits the writeback debug trace.

## Interface
Parameters:
- `PC_W`, 32: width of the traced PC.

Ports:
- `clk` in 1: core clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the WB contents; ignore MEM inputs.
- `flush` in 1: load a bubble (`valid`=0) on the next edge; has priority over `stall`.
- `m_valid` in 1: MEM-stage instruction valid.
- `m_pc` in PC_W: MEM-stage PC.
- `m_regwrite` in 1: instruction writes a GPR.
- `m_wa` in 5: destination register.
- `m_memtoreg` in 1: 1 = result from load data; 0 = `m_alu`.
- `m_alu` in 32: ALU/HI/LO/link result.
- `m_ldtype` in 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR.
- `m_addr_lo` in 2: byte offset of the load address.
- `m_rt_old` in 32: old rt value, used for LWL/LWR merging.
- `data_sram_rdata` in 32: SRAM read data; valid in the first cycle the load occupies WB.
- `rf_we` out 1: register-file write enable.
- `rf_wa` out 5: register-file write address.
- `rf_wd` out 32: register-file write data.
- `debug_wb_pc` out PC_W: PC of the instruction in WB.
- `debug_wb_rf_wen` out 4: byte enables of the trace write.
- `debug_wb_rf_wnum` out 5: trace register number.
- `debug_wb_rf_wdata` out 32: trace write data.

## Operation
- **Pipeline register** (`valid`, `pc`, `regwrite`, `wa`, `memtoreg`, `ldtype`, `addr_lo`, `alu`, `rt_old`), updated on the rising edge by priority:
  - `flush`: `valid`=0; other fields don't-care.
  - otherwise `stall`: hold.
  - otherwise: load the `m_*` inputs.
- **Read-data hold FSM**, states FRESH and HELD:
  - Any register load (new instruction or bubble) → FRESH.
  - In FRESH, with `stall`=1 and `flush`=0: capture `data_sram_rdata` into `rdata_q` and go to HELD.
  - In HELD: stay until the register loads again.
  - Effective data `rd` = `data_sram_rdata` in FRESH, `rdata_q` in HELD.
- **Load extraction**: byte/half selected by `addr_lo`, little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LH/LHU use `addr_lo[1]` only.
  - LW passes `rd` through.
- **Result**: `rf_wd` = `memtoreg` ? extracted load : `alu`.
- **Write enable**: `rf_we` = `valid` & `regwrite` & (`wa`≠0) & ~`stall`.
  - Suppressing the write during stall gives exactly one write per instruction, on its final WB cycle.
  - `rf_wa` = `wa`.
- **Debug trace**:
  - `debug_wb_rf_wen` = {4{`rf_we`}}.
  - `debug_wb_rf_wnum` = `wa`; `debug_wb_rf_wdata` = `rf_wd`; `debug_wb_pc` = `pc`.

## Timing
- **Latency**: an instruction is in MEM in cycle N and drives `rf_*` in cycle N+1. The register file writes at the falling edge of N+1, so a decode-stage read in N+1 sees the value. No extra bypass is needed from this block.
- **Reset**: all outputs are 0, `valid`=0, `rdata_q`=0, FSM=FRESH. Reset is asynchronous and may assert mid-stall; the held load is discarded with no write.
- **Stall**: `stall` asserted for k cycles keeps `rf_we`=0 for those cycles. The write fires in the first unstalled cycle with data captured in the first WB cycle, even if the SRAM data bus changed meanwhile.
- **Simultaneous `flush` and `stall`**: flush wins; the pending instruction is dropped unwritten.
- **Invalid `m_ldtype` (111)**: `rf_we` still follows `regwrite`; data = `rd`, treated as LW.

## Configuration
- **`MEM_WB_LWLR_EN` defined**:
  - LWL writes bytes 3..(3-`addr_lo`) from `rd` bytes `addr_lo`..0 and keeps the remaining low bytes from `rt_old`.
  - LWR writes bytes (3-`addr_lo`)..0 from `rd` bytes 3..`addr_lo` and keeps the remaining high bytes from `rt_old`.
- **Undefined**: types 101/110 force `rf_we`=0. The `rt_old` register is removed.

## Test plan
- **Reset**: assert `resetn`=0 mid-run → all outputs 0 immediately; first write appears only after a valid MEM instruction following release.
- **ALU writeback**: `m_regwrite`=1, `m_wa`=8, `m_alu`=0x12345678 → next cycle `rf_we`=1, `rf_wa`=8, `rf_wd`=0x12345678. With `m_wa`=0 → `rf_we`=0.
- **Load extraction**, `rdata`=0x80FF7F01:
  - LB at offset 2 → 0xFFFFFFFF.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
  - LHU at offset 0 → 0x00007F01.
- **Stall hold**: LW with `rdata`=0xDEADBEEF, `stall`=1 for 3 cycles, bus changed to 0 after cycle 1 → `rf_we`=0 for 3 cycles, then one write of 0xDEADBEEF.
- **Flush priority**: `flush`=1 and `stall`=1 together on a pending LW → no write ever occurs; next instruction writes normally.
- **LWL/LWR (macro on)**: `rt_old`=0x11223344, `rdata`=0xAABBCCDD:
  - LWL at offset 1 → 0xCCDD3344.
  - LWR at offset 1 → 0x11AABBCC.
  - Macro off: both give `rf_we`=0.
